// File: rtl/cache_refill_arb_if.sv
// cache_refill_arb_if: AXI4 read address and read data channels.
// master drives AR and rready; slave drives arready and the R beat.
interface cache_refill_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [3:0]        arid;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arid,
    output arsize, arburst, rready,
    input  arready, rvalid, rdata,
    input  rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arid,
    input  arsize, arburst, rready,
    output arready, rvalid, rdata,
    output rresp, rlast
  );
endinterface

// File: rtl/cache_refill_arb.sv
// cache_refill_arb: shares one AXI4 read port between I/D refills.
// Ports: clk, rst (sync, high), ic_*/dc_* refill side, m (AXI master).
// ARB_ROUND_ROBIN_EN: round-robin on contention, else D-cache wins.
module cache_refill_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [LEN_W-1:0]  ic_len,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rlast,
  output logic              ic_rerr,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LEN_W-1:0]  dc_len,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rlast,
  output logic              dc_rerr,
  cache_refill_arb_if.master m
);
  typedef enum logic [1:0] {
    IDLE,
    AR,
    R
  } state_t;

  state_t            state;
  logic              owner;
  logic              sticky;
  logic              arvalid_q;
  logic              rready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              pick;
  logic              ar_hs;
  logic              beat;
  logic              bad;
  logic              rerr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;
  assign pick = (ic_req & dc_req) ? ~last_owner : dc_req;
`else
  assign pick = dc_req;
`endif

  assign ar_hs = arvalid_q & m.arready;
  assign beat  = rready_q & m.rvalid;
  assign bad   = m.rresp != 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      sticky    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (ic_req | dc_req) begin
            owner     <= pick;
            addr_q    <= pick ? dc_addr : ic_addr;
            len_q     <= pick ? dc_len : ic_len;
            sticky    <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= owner;
`endif
          end
        end
        R: begin
          if (m.rvalid) begin
            if (bad) sticky <= 1'b1;
            if (m.rlast) begin
              rready_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // error covers earlier beats (sticky) and the last beat itself
  assign rerr = (sticky | bad) & m.rvalid
              & m.rlast & rready_q;

  assign ic_gnt    = ar_hs & ~owner;
  assign dc_gnt    = ar_hs & owner;
  assign ic_rvalid = beat & ~owner;
  assign dc_rvalid = beat & owner;
  assign ic_rlast  = beat & m.rlast & ~owner;
  assign dc_rlast  = beat & m.rlast & owner;
  assign ic_rerr   = rerr & ~owner;
  assign dc_rerr   = rerr & owner;
  assign ic_rdata  = m.rdata;
  assign dc_rdata  = m.rdata;

  assign m.arvalid = arvalid_q;
  assign m.araddr  = addr_q;
  assign m.arlen   = len_q;
  assign m.arid    = {3'b000, owner};
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign m.rready  = rready_q;
endmodule

// File: tb/tb_cache_refill_arb.sv
// tb_cache_refill_arb: random and directed refills vs a reference model.
// The bench plays both caches and the AXI slave.
module tb_cache_refill_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, dc_req;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] ic_len, dc_len;
  logic          ic_gnt, ic_rvalid, ic_rlast, ic_rerr;
  logic          dc_gnt, dc_rvalid, dc_rlast, dc_rerr;
  logic [DW-1:0] ic_rdata, dc_rdata;

  cache_refill_arb_if #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) bus ();

  cache_refill_arb #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_len(ic_len), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .ic_rlast(ic_rlast), .ic_rerr(ic_rerr),
    .dc_req(dc_req), .dc_addr(dc_addr),
    .dc_len(dc_len), .dc_gnt(dc_gnt),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_rlast(dc_rlast), .dc_rerr(dc_rerr),
    .m(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // reference model state
  bit            last_own = 1'b0;
  int            ic_err = -1, dc_err = -1;
  int            phase = 0;
  int            ar_dly = 0, fix_dly = -1;
  int            beat = 0, blen = 0, ebeat = -1;
  int            pend = 0, nb = 0, done = 0, gap = 0;
  bit            own = 1'b0, smp_ic = 1'b0, smp_dc = 1'b0;
  bit            tog = 1'b0, hold = 1'b0, drop = 1'b0;
  bit            seen_rerr = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  bit            grants[$];

  function automatic bit arb(input bit i, input bit d);
`ifdef ARB_ROUND_ROBIN_EN
    if (i && d) return !last_own;
`endif
    return d;
  endfunction

  function automatic int rand_err();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 7));
    return -1;
  endfunction

  task automatic raise(input bit d, input logic [AW-1:0] a,
                       input int len, input int eb);
    if (d) begin
      dc_req = 1'b1; dc_addr = a;
      dc_len = LW'(len); dc_err = eb;
    end else begin
      ic_req = 1'b1; ic_addr = a;
      ic_len = LW'(len); ic_err = eb;
    end
  endtask

  task automatic step();
    int p;
    bit rv, rdy, lst;
    logic [1:0] sel;
    @(negedge clk);
    p = phase;
    rdy = (p == 1) && (ar_dly == 0);
    rv = 1'b0;
    if (p == 2) begin
      case (gap)
        0: rv = 1'b1;
        1: rv = tog;
        default: rv = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
    end
    lst = rv && (beat == blen);
    bus.arready = rdy;
    bus.rvalid = rv;
    bus.rdata = $urandom;
    bus.rlast = lst;
    bus.rresp = (rv && beat == ebeat) ? 2'b10 : 2'b00;
    #1;
    sel = own ? 2'b01 : 2'b10;
    case (p)
      0: begin
        check("rready_idle", bus.rready, 0);
        check("gnt_idle", {ic_gnt, dc_gnt}, 0);
        check("rvalid_idle", {ic_rvalid, dc_rvalid}, 0);
        if (bus.arvalid) begin
          own = arb(smp_ic, smp_dc);
          exp_addr = own ? dc_addr : ic_addr;
          check("ar_latency", pend, 1);
          check("arid", bus.arid, {3'b000, own});
          check("araddr", bus.araddr, exp_addr);
          check("arlen", bus.arlen,
                own ? dc_len : ic_len);
          check("arsize_burst",
                {bus.arsize, bus.arburst}, 5'b01001);
          blen = own ? int'(dc_len) : int'(ic_len);
          ebeat = own ? dc_err : ic_err;
          phase = 1;
          pend = 0;
          ar_dly = (fix_dly >= 0) ? fix_dly
                 : int'($urandom_range(0, 2));
        end else begin
          smp_ic = ic_req;
          smp_dc = dc_req;
          if (ic_req || dc_req) pend++;
        end
      end
      1: begin
        check("arvalid_hold", bus.arvalid, 1);
        check("araddr_hold", bus.araddr, exp_addr);
        check("gnt", {ic_gnt, dc_gnt},
              rdy ? sel : 2'b00);
        if (rdy) begin
          phase = 2; beat = 0; nb = 0;
          last_own = own;
          grants.push_back(own);
          drop = 1'b1;
        end else ar_dly--;
      end
      default: begin
        check("rready", bus.rready, 1);
        check("gnt_busy", {ic_gnt, dc_gnt}, 0);
        check("rvalid", {ic_rvalid, dc_rvalid},
              rv ? sel : 2'b00);
        check("rlast", {ic_rlast, dc_rlast},
              lst ? sel : 2'b00);
        check("rerr", {ic_rerr, dc_rerr},
              (lst && ebeat >= 0 && ebeat <= blen)
              ? sel : 2'b00);
        if (own ? dc_rvalid : ic_rvalid) nb++;
        if (rv) begin
          check("rdata", own ? dc_rdata : ic_rdata,
                bus.rdata);
          if (lst) begin
            seen_rerr = own ? dc_rerr : ic_rerr;
            check("nbeats", nb, blen + 1);
            phase = 0;
            done++;
          end
          beat++;
        end
      end
    endcase
    @(posedge clk);
    #1;
    if (drop && !hold) begin
      if (own) dc_req = 1'b0;
      else ic_req = 1'b0;
    end
    drop = 1'b0;
  endtask

  task automatic run(input int n, input bit rnd);
    int tgt, b;
    tgt = done + n;
    b = 0;
    while (done < tgt && b < 3000) begin
      step();
      b++;
      if (rnd) begin
        if (!ic_req && $urandom_range(0, 3) == 0)
          raise(0, $urandom, $urandom_range(0, 7),
                rand_err());
        if (!dc_req && $urandom_range(0, 3) == 0)
          raise(1, $urandom, $urandom_range(0, 7),
                rand_err());
      end
    end
    check("timeout", done >= tgt, 1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((ic_req || dc_req || phase != 0) && b < 3000) begin
      step();
      b++;
    end
    check("drain", phase, 0);
    step();
  endtask

  logic [3:0] gseq;
  int b;

  initial begin
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0;
    ic_addr = '0; dc_addr = '0;
    ic_len = '0; dc_len = '0;
    bus.arready = 1'b1; bus.rvalid = 1'b1;
    bus.rdata = '0; bus.rresp = 2'b10; bus.rlast = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_outs",
          {ic_gnt, ic_rvalid, ic_rlast, ic_rerr,
           dc_gnt, dc_rvalid, dc_rlast, dc_rerr}, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_arlen", bus.arlen, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // I-only refill
    fix_dly = 2;
    raise(0, 32'h1FC0_0000, 3, -1);
    run(1, 0);
    check("i_only_grant", grants[grants.size()-1], 0);
    check("i_only_rerr", seen_rerr, 0);
    fix_dly = -1;
    drain();

    // contention, both len 7
    raise(1, 32'h0000_4000, 7, -1);
    raise(0, 32'h1FC0_0100, 7, -1);
    run(2, 0);
    check("cont_first",
          grants[grants.size()-2], 1);
    check("cont_second",
          grants[grants.size()-1], 0);
    drain();

    // both requesters held over 4 bursts
    hold = 1'b1;
    raise(1, 32'h0000_8000, 1, -1);
    raise(0, 32'h1FC0_0200, 1, -1);
    run(4, 0);
    ic_req = 1'b0;
    dc_req = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 4; i++)
      gseq[3-i] = grants[grants.size()-4+i];
`ifdef ARB_ROUND_ROBIN_EN
    check("rr_seq", gseq, 4'b1010);
`else
    check("rr_seq", gseq, 4'b1111);
`endif
    drain();

    // error path then clean burst
    raise(1, 32'h0000_C000, 3, 1);
    run(1, 0);
    check("err_rerr", seen_rerr, 1);
    raise(1, 32'h0000_C040, 3, -1);
    run(1, 0);
    check("clean_rerr", seen_rerr, 0);
    drain();

    // back-pressure with a late I request
    gap = 1;
    raise(1, 32'h0001_0000, 7, -1);
    b = 0;
    while (phase != 2 && b < 100) begin
      step();
      b++;
    end
    raise(0, 32'h1FC0_0300, 5, -1);
    run(2, 0);
    check("late_first", grants[grants.size()-2], 1);
    check("late_second", grants[grants.size()-1], 0);
    drain();

    // random traffic
    gap = 2;
    run(20, 1);
    drain();

    // reset after two beats of an 8-beat burst
    gap = 0;
    raise(1, 32'h0002_0000, 7, -1);
    b = 0;
    while (!(phase == 2 && beat == 2) && b < 100) begin
      step();
      b++;
    end
    rst = 1'b1;
    dc_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    bus.arready = 1'b1; bus.rvalid = 1'b1;
    bus.rlast = 1'b1; bus.rresp = 2'b10;
    #1;
    check("mrst_rready", bus.rready, 0);
    check("mrst_arvalid", bus.arvalid, 0);
    check("mrst_outs",
          {ic_gnt, ic_rvalid, ic_rlast, ic_rerr,
           dc_gnt, dc_rvalid, dc_rlast, dc_rerr}, 0);
    phase = 0; pend = 0; last_own = 1'b0;
    smp_ic = 1'b0; smp_dc = 1'b0;
    @(posedge clk);
    #1;
    raise(0, 32'h1FC0_0400, 3, -1);
    run(1, 0);
    check("post_rst_grant", grants[grants.size()-1], 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end
endmodule
